// File: rtl/dcache_pkg.sv
// Shared types and byte-lane helpers for the direct-mapped data cache.
// Byte-lane logic assumes 32-bit words (four lanes).
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE
    } cache_state_t;

    function automatic logic [3:0] byte_en(
        input logic [1:0] addr_lo,
        input logic       byte_addr
    );
        return byte_addr ? 4'(4'b0001 << addr_lo) : 4'hF;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read port, one byte-enabled write port.
// Only the valid vector is reset; tag/data are qualified by valid.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SETS  = 8,
    parameter int IDX   = $clog2(SETS),
    parameter int TAGW  = WIDTH - 2 - IDX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX-1:0]   rd_idx,
    output logic             rd_valid,
    output logic [TAGW-1:0]  rd_tag,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX-1:0]   wr_idx,
    input  logic [TAGW-1:0]  wr_tag,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       wr_be
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]  tag_q  [SETS];
    logic [TAGW-1:0]  tag_d  [SETS];
    logic [WIDTH-1:0] data_q [SETS];
    logic [WIDTH-1:0] data_d [SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = lane_merge(data_q[wr_idx], wr_data, wr_be);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with a
// single-outstanding req/ready memory port.
module data_cache
    import dcache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SETS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             we,
    input  logic             byte_addr,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = WIDTH - 2 - IDX;

    cache_state_t state_q, state_d;

    logic [IDX-1:0]   idx;
    logic [TAGW-1:0]  tag;
    logic             rd_valid;
    logic [TAGW-1:0]  rd_tag;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rd_shift;
    logic [WIDTH-1:0] rd_sel;
    logic             hit;
    logic [3:0]       be;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       wr_be;

    assign tag = addr[WIDTH-1:2+IDX];
    assign idx = addr[2+IDX-1:2];
    assign hit = rd_valid && (rd_tag == tag);
    assign be  = byte_en(addr[1:0], byte_addr);

    assign rd_shift = rd_data >> {addr[1:0], 3'b000};
    assign rd_sel   = byte_addr ? {{(WIDTH-8){1'b0}}, rd_shift[7:0]} : rd_data;

    // Core holds its request stable while stalled, so these stay put until mem_ready.
    assign mem_req   = (state_q != S_IDLE);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = {addr[WIDTH-1:2], 2'b00};
    assign mem_wdata = byte_addr ? {(WIDTH/8){wdata[7:0]}} : wdata;
    assign mem_be    = be;

    dcache_array #(
        .WIDTH (WIDTH),
        .SETS  (SETS),
        .IDX   (IDX),
        .TAGW  (TAGW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (wr_data),
        .wr_be    (wr_be)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        rdata   = '0;
        wr_en   = 1'b0;
        wr_data = mem_rdata;
        wr_be   = 4'hF;
        unique case (state_q)
            S_IDLE: begin
                if (we) begin
                    stall   = 1'b1;
                    state_d = S_WRITE;
                end else if (re) begin
                    if (hit) begin
                        rdata = rd_sel;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                stall = 1'b1;
                if (mem_ready) begin
                    wr_en   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                // Release in the ready cycle so the store retires exactly once.
                stall = !mem_ready;
                if (mem_ready) begin
                    wr_en   = hit;
                    wr_data = mem_wdata;
                    wr_be   = be;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
